// File: rtl/rasterizer_depth_test_writeback.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_depth_test_writeback
// Purpose  : Buffers fetched fragments, runs the depth test and writes colour
//            and depth words for passing fragments over an Avalon-MM master.
// Revision : 1.0 - initial release
// ============================================================================
module rasterizer_depth_test_writeback #(
    parameter int FIFO_DEPTH = 8,
    parameter int SKID       = 4,
    parameter int PASS_EQUAL = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        input_valid,
    input  logic [25:0] addr_in,
    input  logic [23:0] color_in,
    input  logic [31:0] old_depth_in,
    input  logic [31:0] new_depth_in,
    input  logic        done_in,
    output logic        stall_out,
    output logic        done_out,
    output logic [25:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [3:0]  master_byteenable,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] pass_count,
    output logic [31:0] fail_count,
    output logic        overflow
);

    localparam int              c_AW     = $clog2(FIFO_DEPTH);
    localparam int              c_EW     = 115;
    localparam logic [c_AW:0]   c_FULL   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_THRESH = (c_AW + 1)'(FIFO_DEPTH - SKID);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_COLOR = 2'd1,
        S_WR_DEPTH = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_stall;
    logic            r_overflow;

    state_t          r_state;
    logic [25:0]     r_addr;
    logic [31:0]     r_new_depth;
    logic            r_done;
    logic            r_done_out;
    logic            r_mwrite;
    logic [25:0]     r_maddr;
    logic [31:0]     r_mdata;
    logic [31:0]     r_pass_count;
    logic [31:0]     r_fail_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;
    logic            w_head_done;
    logic [31:0]     w_head_new;
    logic [31:0]     w_head_old;
    logic [23:0]     w_head_color;
    logic [25:0]     w_head_addr;
    logic            w_pass;
    logic [c_AW:0]   w_count_next;

    assign w_full       = (r_count == c_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = input_valid && !w_full;
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_count_next = r_count + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_pop);

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_done  = w_head[114];
    assign w_head_new   = w_head[113:82];
    assign w_head_old   = w_head[81:50];
    assign w_head_color = w_head[49:26];
    assign w_head_addr  = w_head[25:0];

    // Unsigned compare; equality only passes when the instance is built for it
    assign w_pass = (w_head_new < w_head_old) ||
                    ((PASS_EQUAL != 0) && (w_head_new == w_head_old));

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {done_in, new_depth_in, old_depth_in, color_in, addr_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (input_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_stall <= (w_count_next >= c_THRESH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_new_depth  <= '0;
            r_done       <= 1'b0;
            r_done_out   <= 1'b0;
            r_mwrite     <= 1'b0;
            r_maddr      <= '0;
            r_mdata      <= '0;
            r_pass_count <= '0;
            r_fail_count <= '0;
        end else begin
            r_done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_addr      <= w_head_addr;
                        r_new_depth <= w_head_new;
                        r_done      <= w_head_done;
                        if (w_pass) begin
                            r_pass_count <= r_pass_count + 32'd1;
                            r_mwrite     <= 1'b1;
                            r_maddr      <= w_head_addr;
                            r_mdata      <= {8'h00, w_head_color};
                            r_state      <= S_WR_COLOR;
                        end else begin
                            r_fail_count <= r_fail_count + 32'd1;
                            if (w_head_done) begin
                                r_done_out <= 1'b1;
                                r_state    <= S_DONE;
                            end
                        end
                    end
                end
                S_WR_COLOR: begin
                    if (!master_waitrequest) begin
                        r_maddr <= r_addr + 26'd4;
                        r_mdata <= r_new_depth;
                        r_state <= S_WR_DEPTH;
                    end
                end
                S_WR_DEPTH: begin
                    if (!master_waitrequest) begin
                        r_mwrite <= 1'b0;
                        r_maddr  <= '0;
                        r_mdata  <= '0;
                        if (r_done) begin
                            r_done_out <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_out         = r_stall;
    assign done_out          = r_done_out;
    assign master_address    = r_maddr;
    assign master_read       = 1'b0;
    assign master_write      = r_mwrite;
    assign master_byteenable = {4{r_mwrite}};
    assign master_writedata  = r_mdata;
    assign pass_count        = r_pass_count;
    assign fail_count        = r_fail_count;
    assign overflow          = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rasterizer_depth_test_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_rasterizer_depth_test_writeback
// Purpose  : Directed, table-driven bench for the depth-test write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rasterizer_depth_test_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        input_valid;
    logic [25:0] addr_in;
    logic [23:0] color_in;
    logic [31:0] old_depth_in;
    logic [31:0] new_depth_in;
    logic        done_in;
    logic        master_waitrequest;

    logic        stall_out, done_out, master_read, master_write, overflow;
    logic [25:0] master_address;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata, pass_count, fail_count;

    logic        stall_1, done_1, read_1, write_1, ovf_1;
    logic [25:0] addr_1;
    logic [3:0]  be_1;
    logic [31:0] wdata_1, pc_1, fc_1;

    rasterizer_depth_test_writeback #(.FIFO_DEPTH(8), .SKID(4), .PASS_EQUAL(0)) dut (
        .clock(clock), .reset(reset), .input_valid(input_valid), .addr_in(addr_in),
        .color_in(color_in), .old_depth_in(old_depth_in), .new_depth_in(new_depth_in),
        .done_in(done_in), .stall_out(stall_out), .done_out(done_out),
        .master_address(master_address), .master_read(master_read),
        .master_write(master_write), .master_byteenable(master_byteenable),
        .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
        .pass_count(pass_count), .fail_count(fail_count), .overflow(overflow)
    );

    rasterizer_depth_test_writeback #(.FIFO_DEPTH(8), .SKID(4), .PASS_EQUAL(1)) dut_eq (
        .clock(clock), .reset(reset), .input_valid(input_valid), .addr_in(addr_in),
        .color_in(color_in), .old_depth_in(old_depth_in), .new_depth_in(new_depth_in),
        .done_in(done_in), .stall_out(stall_1), .done_out(done_1),
        .master_address(addr_1), .master_read(read_1),
        .master_write(write_1), .master_byteenable(be_1),
        .master_writedata(wdata_1), .master_waitrequest(master_waitrequest),
        .pass_count(pc_1), .fail_count(fc_1), .overflow(ovf_1)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { logic [25:0] a; logic [31:0] d; int c; } wr_t;
    typedef struct { logic [25:0] a; logic [23:0] col; logic [31:0] od; logic [31:0] nd; bit p0; bit p1; } vec_t;

    wr_t wq[$];
    int  dq[$];
    int  n1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Samples just before each rising edge, when a write is actually accepted
    always @(negedge clock) begin
        #4;
        if (!reset) begin
            chk("byteenable", {master_read, master_byteenable}, master_write ? 5'h0F : 5'h00);
            if (master_write && !master_waitrequest) wq.push_back('{master_address, master_writedata, cyc});
            if (done_out) dq.push_back(cyc);
            if (write_1 && !master_waitrequest) n1++;
        end
    end

    task automatic drive(input logic [25:0] a, input logic [23:0] c, input logic [31:0] od,
                         input logic [31:0] nd, input logic dn, output int tc);
        @(negedge clock);
        addr_in      = a;
        color_in     = c;
        old_depth_in = od;
        new_depth_in = nd;
        done_in      = dn;
        input_valid  = 1'b1;
        tc           = cyc + 1;
    endtask

    task automatic idle();
        @(negedge clock);
        input_valid = 1'b0;
        done_in     = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int budget, input string nm);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk({nm, "_writes"}, 64'(wq.size()), 64'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[6];
        int          tc, tc3, k, ep0, ef0, ep1, cw;
        logic [25:0] ea, a0;
        logic [31:0] d0;

        vt[0] = '{26'h0000100, 24'hABCDEF, 32'd500,        32'd100,        1'b1, 1'b1};
        vt[1] = '{26'h0000200, 24'h123456, 32'd100,        32'd200,        1'b0, 1'b0};
        vt[2] = '{26'h0000300, 24'h000001, 32'd50,         32'd50,         1'b0, 1'b1};
        vt[3] = '{26'h3FFFFFC, 24'hFFFFFF, 32'hFFFFFFFF,   32'h00000000,   1'b1, 1'b1};
        vt[4] = '{26'h0000040, 24'h00C0DE, 32'h80000000,   32'h7FFFFFFF,   1'b1, 1'b1};
        vt[5] = '{26'h0000080, 24'h0BAD00, 32'h7FFFFFFF,   32'h80000000,   1'b0, 1'b0};

        reset = 1'b1; input_valid = 1'b0; done_in = 1'b0; master_waitrequest = 1'b0;
        addr_in = '0; color_in = '0; old_depth_in = '0; new_depth_in = '0;
        ep0 = 0; ef0 = 0; ep1 = 0; n1 = 0;

        repeat (3) @(negedge clock);
        chk("rst_stall", stall_out, 1'b1);
        chk("rst_write", master_write, 1'b0);
        chk("rst_read", master_read, 1'b0);
        chk("rst_be", master_byteenable, 4'h0);
        chk("rst_addr", master_address, 26'h0);
        chk("rst_data", master_writedata, 32'h0);
        chk("rst_pass", pass_count, 32'd0);
        chk("rst_fail", fail_count, 32'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_done", done_out, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("rel_stall", stall_out, 1'b0);

        for (int i = 0; i < 6; i++) begin
            wq.delete();
            n1 = 0;
            drive(vt[i].a, vt[i].col, vt[i].od, vt[i].nd, 1'b0, tc);
            idle();
            repeat (8) @(negedge clock);
            ep0 += int'(vt[i].p0);
            ef0 += int'(!vt[i].p0);
            ep1 += int'(vt[i].p1);
            ea = vt[i].a + 26'd4;
            chk($sformatf("v%0d_nwr", i), 64'(wq.size()), vt[i].p0 ? 64'd2 : 64'd0);
            if (vt[i].p0 && wq.size() == 2) begin
                chk($sformatf("v%0d_caddr", i), wq[0].a, vt[i].a);
                chk($sformatf("v%0d_cdata", i), wq[0].d, {8'h00, vt[i].col});
                chk($sformatf("v%0d_daddr", i), wq[1].a, ea);
                chk($sformatf("v%0d_ddata", i), wq[1].d, vt[i].nd);
                chk($sformatf("v%0d_ccyc", i), 64'(wq[0].c), 64'(tc + 1));
                chk($sformatf("v%0d_dcyc", i), 64'(wq[1].c), 64'(tc + 2));
            end
            chk($sformatf("v%0d_pass", i), pass_count, 32'(ep0));
            chk($sformatf("v%0d_fail", i), fail_count, 32'(ef0));
            chk($sformatf("v%0d_eq_nwr", i), 64'(n1), vt[i].p1 ? 64'd2 : 64'd0);
            chk($sformatf("v%0d_eq_pass", i), pc_1, 32'(ep1));
        end

        // Colour write held off by waitrequest for three cycles
        @(negedge clock);
        master_waitrequest = 1'b1;
        wq.delete();
        drive(26'h0000600, 24'h55AA33, 32'd900, 32'd300, 1'b0, tc);
        idle();
        k = 0;
        while (master_write !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("wr_start", master_write, 1'b1);
        a0 = master_address;
        d0 = master_writedata;
        chk("wr_caddr", a0, 26'h0000600);
        chk("wr_cdata", d0, 32'h0055AA33);
        for (int h = 0; h < 2; h++) begin
            @(negedge clock);
            chk("wr_hold_addr", master_address, a0);
            chk("wr_hold_data", master_writedata, d0);
            chk("wr_hold_write", master_write, 1'b1);
        end
        cw = cyc;
        master_waitrequest = 1'b0;
        wait_wr(2, 10, "wr");
        if (wq.size() >= 2) begin
            chk("wr_ccyc", 64'(wq[0].c), 64'(cw));
            chk("wr_dcyc", 64'(wq[1].c), 64'(cw + 1));
            chk("wr_daddr", wq[1].a, 26'h0000604);
            chk("wr_ddata", wq[1].d, 32'd300);
        end
        ep0++;

        // Back-to-back passing fragments
        wq.delete();
        for (int i = 0; i < 8; i++) begin
            drive(26'h0001000 + 26'(16 * i), 24'(i), 32'd1000, 32'(i), 1'b0, tc);
            if (i == 5) chk("bp_stall_below", stall_out, 1'b0);
            if (i == 6) chk("bp_stall_at", stall_out, 1'b1);
        end
        idle();
        wait_wr(16, 100, "bp");
        if (wq.size() >= 16) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("bp%0d_caddr", i), wq[2*i].a, 26'h0001000 + 26'(16 * i));
                chk($sformatf("bp%0d_daddr", i), wq[2*i+1].a, 26'h0001004 + 26'(16 * i));
                chk($sformatf("bp%0d_ddata", i), wq[2*i+1].d, 32'(i));
            end
        end
        ep0 += 8;
        chk("bp_ovf", overflow, 1'b0);
        repeat (3) @(negedge clock);
        chk("bp_stall_drained", stall_out, 1'b0);

        // Working registers blocked, then nine pushes into an eight-entry FIFO
        @(negedge clock);
        master_waitrequest = 1'b1;
        wq.delete();
        drive(26'h0002000, 24'h111111, 32'd5, 32'd1, 1'b0, tc);
        idle();
        repeat (3) @(negedge clock);
        for (int i = 0; i < 9; i++) begin
            drive(26'h0003000 + 26'(16 * i), 24'h222222, 32'd1000, 32'd1, 1'b0, tc);
            if (i == 8) chk("of_full_no_ovf", overflow, 1'b0);
        end
        idle();
        chk("of_ovf_set", overflow, 1'b1);
        master_waitrequest = 1'b0;
        wait_wr(18, 150, "of");
        repeat (10) @(negedge clock);
        chk("of_total_writes", 64'(wq.size()), 64'd18);
        if (wq.size() >= 18) chk("of_last_addr", wq[16].a, 26'h0003070);
        chk("of_ovf_sticky", overflow, 1'b1);
        ep0 += 9;
        chk("of_pass", pass_count, 32'(ep0));
        chk("of_fail", fail_count, 32'(ef0));

        // Done marker on a failing third fragment
        wq.delete();
        dq.delete();
        drive(26'h0004000, 24'h0, 32'd10, 32'd20, 1'b0, tc);
        drive(26'h0004010, 24'h0, 32'd10, 32'd20, 1'b0, tc);
        drive(26'h0004020, 24'h0, 32'd10, 32'd20, 1'b1, tc3);
        idle();
        repeat (8) @(negedge clock);
        ef0 += 3;
        chk("df_pulses", 64'(dq.size()), 64'd1);
        if (dq.size() >= 1) chk("df_cyc", 64'(dq[0]), 64'(tc3 + 1));
        chk("df_nwr", 64'(wq.size()), 64'd0);
        chk("df_fail", fail_count, 32'(ef0));

        // Done marker on a passing third fragment
        wq.delete();
        dq.delete();
        drive(26'h0005000, 24'h0, 32'd10, 32'd1, 1'b0, tc);
        drive(26'h0005010, 24'h0, 32'd10, 32'd2, 1'b0, tc);
        drive(26'h0005020, 24'h0, 32'd10, 32'd3, 1'b1, tc3);
        idle();
        wait_wr(6, 60, "dp");
        repeat (5) @(negedge clock);
        ep0 += 3;
        chk("dp_pulses", 64'(dq.size()), 64'd1);
        if (dq.size() >= 1 && wq.size() >= 6) begin
            chk("dp_cyc", 64'(dq[0]), 64'(wq[5].c + 1));
            chk("dp_last_addr", wq[5].a, 26'h0005024);
        end
        chk("dp_pass", pass_count, 32'(ep0));

        // Reset while the depth write is stalled
        drive(26'h0000500, 24'h777777, 32'd80, 32'd8, 1'b0, tc);
        idle();
        k = 0;
        while (!(master_write === 1'b1 && master_address === 26'h0000504) && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("rm_in_depth", {master_write, master_address}, {1'b1, 26'h0000504});
        master_waitrequest = 1'b1;
        @(negedge clock);
        chk("rm_stuck", master_write, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("rm_write", master_write, 1'b0);
        chk("rm_addr", master_address, 26'h0);
        chk("rm_pass", pass_count, 32'd0);
        chk("rm_fail", fail_count, 32'd0);
        chk("rm_ovf", overflow, 1'b0);
        chk("rm_stall", stall_out, 1'b1);
        reset = 1'b0;
        master_waitrequest = 1'b0;
        @(negedge clock);
        chk("rm_stall_rel", stall_out, 1'b0);
        chk("rm_write_rel", master_write, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rasterizer_depth_test_writeback.md
# rasterizer_depth_test_writeback

Depth-test and write-back stage of the rasterizer pipeline, directly downstream of the depth fetch stage. It buffers fragments that arrive with their fetched old depth, compares new against old depth, and, for each passing fragment, writes the colour word and the new depth word to SDRAM over an Avalon-MM master. It also signals pipeline completion when the fragment carrying the done marker retires, and keeps pass/fail statistics.

## Interface
Parameters:
- FIFO_DEPTH, 8: skid FIFO entries (power of two, ≥ 4).
- SKID, 4: free entries reserved for in-flight upstream reads; must be < FIFO_DEPTH.
- PASS_EQUAL, 0: 1 = fragment passes when new_depth == old_depth.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- input_valid  in  1  fragment present on inputs this cycle; no handshake, must be captured.
- addr_in  in  26  pixel colour-word byte address; depth word is at addr_in+4.
- color_in  in  24  fragment colour.
- old_depth_in  in  32  depth currently in memory.
- new_depth_in  in  32  fragment depth.
- done_in  in  1  fragment is the last of the draw.
- stall_out  out  1  to upstream stall_in: stop issuing new fetches.
- done_out  out  1  one-cycle pulse: last fragment retired.
- master_address  out  26  Avalon address.
- master_read  out  1  tied 0.
- master_write  out  1  Avalon write request.
- master_byteenable  out  4  4'b1111 whenever master_write = 1, else 0.
- master_writedata  out  32  write data.
- master_waitrequest  in  1  Avalon stall.
- pass_count  out  32  fragments passed since reset.
- fail_count  out  32  fragments rejected since reset.
- overflow  out  1  sticky: a fragment was dropped on a full FIFO.

## Operation
- FIFO entry is 115 bits: {done, new_depth, old_depth, color, addr}. Push when input_valid && !full; push while full is dropped (even with a simultaneous pop) and sets overflow.
- stall_out is registered: 1 when occupancy (after this cycle's push/pop) ≥ FIFO_DEPTH − SKID, else 0.
- Depth test, unsigned: pass = new < old, or new == old when PASS_EQUAL = 1.
- FSM states: S_IDLE, S_WR_COLOR, S_WR_DEPTH, S_DONE.
  - S_IDLE: if FIFO is non-empty, pop the head into the working registers and evaluate the test on the head. Pass: pass_count++, go to S_WR_COLOR. Fail: fail_count++, go to S_DONE if done, else stay in S_IDLE. Empty: stay in S_IDLE.
  - S_WR_COLOR: master_write = 1, address = addr, writedata = {8'h00, color}. Hold all of these until !master_waitrequest, then go to S_WR_DEPTH.
  - S_WR_DEPTH: master_write = 1, address = (addr + 4) mod 2^26, writedata = new_depth. On !master_waitrequest, go to S_DONE if done, else S_IDLE.
  - S_DONE: done_out = 1 for exactly one cycle, then S_IDLE.
- Master outputs are decoded from the registered state and working registers only; there is no combinational path from master_waitrequest or the inputs.
- Counters wrap mod 2^32.

## Timing
- Reset values: state S_IDLE, FIFO empty, stall_out = 1, done_out = 0, master_write = 0, master_read = 0, master_byteenable = 0, master_address = 0, master_writedata = 0, pass_count = 0, fail_count = 0, overflow = 0.
- stall_out falls on the first cycle after reset deasserts (if occupancy is low).
- Reset asserted mid-write aborts the write: master_write = 0 on the next cycle and FIFO contents are lost.
- Fragment captured at edge N is at the FIFO head in cycle N+1 and popped in S_IDLE.
- Passing fragment: colour write issued in cycle N+2, depth write in N+3 (no waitrequest), back in S_IDLE at N+4. Steady-state throughput is 3 cycles per pass; each waitrequest cycle adds one.
- Failing fragment: consumes 1 cycle, with no bus traffic.
- Done fragment: done_out pulses in the cycle after its last bus write is accepted, or the cycle after its pop if it failed.
- Push and pop in the same cycle on a non-full FIFO are both honoured; occupancy is unchanged.

## Test plan
- Single pass, no waitrequest: addr 0x100, color 0xABCDEF, old 500, new 100 → writes (0x100, 0x00ABCDEF) then (0x104, 100) in consecutive cycles; pass_count = 1.
- Fail and equal cases: old 100, new 200 → no master_write, fail_count = 1. old = new = 50 with PASS_EQUAL = 0 → fail; with PASS_EQUAL = 1 → pass and two writes.
- Waitrequest: hold master_waitrequest high for 3 cycles during the colour write → address and data stable throughout; depth write follows one cycle after release.
- Backpressure: input_valid every cycle, all passing, FIFO_DEPTH 8, SKID 4 → stall_out = 1 once occupancy ≥ 4, no overflow; all writes in input order. Then force 9 pushes with no drain (waitrequest high) → overflow = 1, 9th fragment not written.
- Done: 3 fragments with done on the third (failing) → done_out is a single pulse, one cycle after the third pop. Repeat with a passing third fragment → pulse one cycle after the 0x…+4 write is accepted.
- Reset mid-operation: assert reset during S_WR_DEPTH with waitrequest high → next cycle master_write = 0, counters = 0, stall_out = 1; stall_out = 0 one cycle after release.
